lm75a_i2c_target: RTL and testbench



---
 rtl/lm75a_i2c_target.sv | 130 +++++++++++++
 tb/tb_lm75a_i2c_target.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lm75a_i2c_target.sv
// lm75a_i2c_target: emulates LM75A temperature-register reads as an open-drain I2C target.
// Ports: clk      - system clock (>= 20x SCL)
//        rst_n    - asynchronous active-low reset
//        temp_in  - 11-bit two's-complement temperature, 0.125 C/LSB
//        scl      - I2C clock from master
//        sda      - I2C data, driven low or released (open-drain)
//        busy     - high while bytes are being served to the master
//        rd_done  - one-cycle pulse after byte1 is shifted out and its ACK/NACK sampled
module lm75a_i2c_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'b1001_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] temp_in,
    input  logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        rd_done
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] TX_BYTE   = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] WAIT_STOP = 3'd5;

    // [1:0] form the synchronizer, [2] is the edge-detect delay
    logic [2:0]  scl_q, sda_q;
    logic [2:0]  state, bit_cnt, nxt_cnt;
    logic [6:0]  shift;
    logic [10:0] shadow;
    logic [7:0]  cur_byte, addr_byte;
    logic        byte_sel, phase, sda_low;
    logic        scl_s, scl_d, sda_s, sda_d, start, stop, scl_rise, scl_fall;

    assign {scl_d, scl_s} = scl_q[2:1];
    assign {sda_d, sda_s} = sda_q[2:1];
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        start     = scl_s && scl_d && sda_d && !sda_s;
        stop      = scl_s && scl_d && !sda_d && sda_s;
        scl_rise  = scl_s && !scl_d;
        scl_fall  = !scl_s && scl_d;
        cur_byte  = byte_sel ? {shadow[2:0], 5'b0} : shadow[10:3];
        addr_byte = {shift, sda_s};
        nxt_cnt   = bit_cnt + 3'd1;
    end

    // phase: in ADDR_ACK marks the ACK bit being driven; in RX_ACK marks an ACK already received
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 3'b111;
            sda_q    <= 3'b111;
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            shadow   <= '0;
            byte_sel <= 1'b0;
            phase    <= 1'b0;
            sda_low  <= 1'b0;
            busy     <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            scl_q   <= {scl_q[1:0], scl};
            sda_q   <= {sda_q[1:0], sda};
            rd_done <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                shadow  <= temp_in;
                sda_low <= 1'b0;
                busy    <= 1'b0;
                phase   <= 1'b0;
            end else if (stop) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
                phase   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift   <= addr_byte[6:0];
                        bit_cnt <= nxt_cnt;
                        if (bit_cnt == 3'd7)
                            state <= (addr_byte == {DEVICE_ADDR, 1'b1}) ? ADDR_ACK : WAIT_STOP;
                    end
                    ADDR_ACK: if (scl_fall) begin
                        phase <= !phase;
                        if (!phase) begin
                            sda_low <= 1'b1;
                        end else begin
                            // byte_sel is cleared here, so present byte0's MSB straight from the shadow
                            state    <= TX_BYTE;
                            byte_sel <= 1'b0;
                            bit_cnt  <= '0;
                            sda_low  <= !shadow[10];
                            busy     <= 1'b1;
                        end
                    end
                    TX_BYTE: if (scl_fall) begin
                        bit_cnt <= nxt_cnt;
                        if (bit_cnt == 3'd7) begin
                            sda_low <= 1'b0;
                            state   <= RX_ACK;
                        end else begin
                            sda_low <= !cur_byte[~nxt_cnt];
                        end
                    end
                    RX_ACK: if (scl_rise && !phase) begin
                        rd_done <= byte_sel;
                        if (sda_s) begin
                            state <= WAIT_STOP;
                            busy  <= 1'b0;
                        end else begin
                            byte_sel <= !byte_sel;
                            phase    <= 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase   <= 1'b0;
                        state   <= TX_BYTE;
                        sda_low <= !cur_byte[7];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lm75a_i2c_target.sv
// tb_lm75a_i2c_target: bit-banged I2C master reading the LM75A emulation, checked against a byte-level model.
module tb_lm75a_i2c_target;
    localparam int Q = 10;

    logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b0;
    logic        busy, rd_done;
    logic [10:0] temp_in = '0;
    wire         sda;
    int          checks = 0, passes = 0, rd_cnt = 0;

    logic [7:0]  got [8];
    logic        t_ack, t_bsy0, t_bsy_end;
    int          t_rds;

    pullup (sda);
    assign sda = sda_m ? 1'b0 : 1'bz;

    lm75a_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .temp_in(temp_in), .scl(scl),
        .sda(sda), .busy(busy), .rd_done(rd_done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rd_done) rd_cnt++;

    typedef struct {
        logic [10:0] temp;
        logic [7:0]  addr;
        int          n;
        logic        ack;
        logic [7:0]  b0, b1;
        int          rd;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic v);
        tick(Q); sda_m = !b; tick(Q); scl = 1'b1; tick(Q); v = sda; tick(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(Q); scl = 1'b1; tick(2*Q); sda_m = 1'b1; tick(2*Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(2*Q); sda_m = 1'b0; tick(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], v);
        xfer_bit(1'b1, v);
        ack = !v;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d, output logic bsy);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, v);
            d[i] = v;
        end
        bsy = busy;
        xfer_bit(!ack, v);
    endtask

    // temp_in = t0 at START, switched to t1 right after it; ACK every byte except the last
    task automatic run_txn(input logic [10:0] t0, input logic [10:0] t1, input logic [7:0] addr,
                           input int n, input logic do_stop);
        int   r0;
        logic b;
        r0 = rd_cnt;
        temp_in = t0;
        i2c_start();
        temp_in = t1;
        write_byte(addr, t_ack);
        t_bsy0 = 1'b0;
        if (t_ack) for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, got[k], b);
            if (k == 0) t_bsy0 = b;
        end
        t_bsy_end = busy;
        if (do_stop) i2c_stop();
        t_rds = rd_cnt - r0;
    endtask

    // LM75A register: 16-bit word = temperature left-aligned; even reads give MSB, odd give LSB
    function automatic logic [7:0] model_byte(input logic [10:0] t, input int k);
        int w;
        w = int'(t) * 32;
        return (k % 2 == 1) ? 8'(w % 256) : 8'(w / 256);
    endfunction

    initial begin
        vec_t        tbl [7];
        logic        a, v, all_hi;
        logic [2:0]  bits3;
        logic [10:0] t0, t1;
        logic [7:0]  addr;
        int          n, w, mag, erd;
        logic        eack;

        tbl[0] = '{11'h0CC, 8'h91, 2, 1'b1, 8'h19, 8'h80, 1};
        tbl[1] = '{11'h738, 8'h91, 2, 1'b1, 8'hE7, 8'h00, 1};
        tbl[2] = '{11'h0CC, 8'h93, 2, 1'b0, 8'h00, 8'h00, 0};
        tbl[3] = '{11'h0CC, 8'h90, 2, 1'b0, 8'h00, 8'h00, 0};
        tbl[4] = '{11'h0CC, 8'h91, 2, 1'b1, 8'h19, 8'h80, 1};
        tbl[5] = '{11'h3FF, 8'h91, 1, 1'b1, 8'h7F, 8'h00, 0};
        tbl[6] = '{11'h400, 8'h91, 2, 1'b1, 8'h80, 8'h00, 1};

        tick(4);
        check("reset busy", busy, 0);
        check("reset rd_done", rd_done, 0);
        check("reset sda", sda, 1);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].temp, tbl[i].temp, tbl[i].addr, tbl[i].n, 1'b1);
            check($sformatf("vec%0d ack", i), t_ack, tbl[i].ack);
            if (tbl[i].ack) begin
                for (int k = 0; k < tbl[i].n; k++)
                    check($sformatf("vec%0d byte%0d", i, k), got[k], k == 0 ? tbl[i].b0 : tbl[i].b1);
                check($sformatf("vec%0d busy during", i), t_bsy0, 1);
            end
            check($sformatf("vec%0d busy end", i), t_bsy_end, 0);
            check($sformatf("vec%0d rd_done count", i), t_rds, tbl[i].rd);
            check($sformatf("vec%0d sda released", i), sda, 1);
            if (tbl[i].temp == 11'h738) begin
                w = int'($signed({got[0], got[1]})) / 32;
                mag = w < 0 ? -w : w;
                check("decode sign", int'(w < 0), 1);
                check("decode tens", (mag / 8) / 10, 2);
                check("decode ones", (mag / 8) % 10, 5);
                check("decode frac", mag % 8, 0);
            end
        end

        // snapshot held for a 4-byte wrapping read, then a repeated start picks up the new value
        run_txn(11'h0CC, 11'h738, 8'h91, 4, 1'b0);
        check("snap byte0", got[0], 8'h19);
        check("snap byte1", got[1], 8'h80);
        check("snap byte2", got[2], 8'h19);
        check("snap byte3", got[3], 8'h80);
        check("snap rd_done count", t_rds, 2);
        check("snap busy end", t_bsy_end, 0);
        run_txn(11'h738, 11'h738, 8'h91, 2, 1'b1);
        check("rep-start byte0", got[0], 8'hE7);
        check("rep-start byte1", got[1], 8'h00);
        check("rep-start rd_done count", t_rds, 1);

        // asynchronous reset while the target drives a 0 bit of byte0
        temp_in = 11'h0CC;
        i2c_start();
        write_byte(8'h91, a);
        check("rst-mid ack", a, 1);
        tick(6);
        check("rst-mid driving 0", sda, 0);
        check("rst-mid busy before", busy, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst-mid sda released", sda, 1);
        check("rst-mid busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        i2c_stop();
        run_txn(11'h0CC, 11'h0CC, 8'h91, 2, 1'b1);
        check("after-rst byte0", got[0], 8'h19);
        check("after-rst byte1", got[1], 8'h80);
        check("after-rst rd_done count", t_rds, 1);

        // STOP in the middle of byte0, then idle clocks must not be answered
        temp_in = 11'h0CC;
        i2c_start();
        write_byte(8'h91, a);
        check("stop-mid ack", a, 1);
        for (int i = 2; i >= 0; i--) begin
            xfer_bit(1'b1, v);
            bits3[i] = v;
        end
        check("stop-mid first bits", bits3, 0);
        tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(2*Q); sda_m = 1'b0; tick(4);
        check("stop-mid sda released", sda, 1);
        check("stop-mid busy", busy, 0);
        all_hi = 1'b1;
        tick(2*Q);
        scl = 1'b0;
        for (int i = 0; i < 9; i++) begin
            xfer_bit(1'b1, v);
            all_hi &= v;
        end
        check("stop-mid idle after", all_hi, 1);
        check("stop-mid busy after", busy, 0);

        // randomized reads against the byte-level model
        for (int i = 0; i < 10; i++) begin
            t0 = 11'($urandom_range(0, 2047));
            t1 = 11'($urandom_range(0, 2047));
            n = $urandom_range(1, 5);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h91;
            eack = (addr[7:1] == 7'h48) && addr[0];
            erd = 0;
            if (eack) for (int k = 0; k < n; k++) if (k % 2 == 1) erd++;
            run_txn(t0, t1, addr, n, 1'b1);
            check($sformatf("rnd%0d ack", i), t_ack, eack);
            if (eack) for (int k = 0; k < n; k++)
                check($sformatf("rnd%0d byte%0d", i, k), got[k], model_byte(t0, k));
            check($sformatf("rnd%0d rd_done count", i), t_rds, erd);
            check($sformatf("rnd%0d busy end", i), t_bsy_end, 0);
            check($sformatf("rnd%0d sda released", i), sda, 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
